// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared types, sizes and column helpers for the key matrix scanner
package kbd_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kbdState_e;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        KEY   = 2'd1,
        MULTI = 2'd2
    } frameRes_e;

    function automatic logic [2:0] countLow(input logic [NUM_COLS-1:0] cols);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (!cols[i]) n = n + 3'd1;
        end
        return n;
    endfunction

    // Index of the lowest-numbered active (low) column; 0 when none are low.
    function automatic logic [1:0] lowestLow(input logic [NUM_COLS-1:0] cols);
        logic [1:0] idx;
        idx = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (!cols[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, resets to all-ones (idle pulled-up level)
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_matrix_scanner.sv
// rtl/key_matrix_scanner.sv - 4x4 active-low matrix scan with frame-level debounce
module key_matrix_scanner
    import kbd_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_COLS-1:0] colIn,
    output logic [NUM_ROWS-1:0] rowOut,
    output logic [3:0]          keyCode,
    output logic                keyValid,
    output logic                keyHeld
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_FRAMES);

    logic [NUM_COLS-1:0] colSync;

    sync_2ff #(.WIDTH(NUM_COLS)) uColSync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (colIn),
        .q     (colSync)
    );

    logic [DIV_W-1:0] divCnt;
    logic [1:0]       rowIdx;
    logic             sampleNow;
    logic             frameDone;

    assign sampleNow = (divCnt == DIV_LAST);
    assign frameDone = sampleNow && (rowIdx == 2'd3);
    assign rowOut    = ~(4'b0001 << rowIdx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt <= '0;
            rowIdx <= '0;
        end else if (sampleNow) begin
            divCnt <= '0;
            rowIdx <= rowIdx + 2'd1;
        end else begin
            divCnt <= divCnt + DIV_W'(1);
        end
    end

    logic [1:0] keyCount;
    logic [3:0] firstCode;
    logic [2:0] rowLows;
    logic [1:0] rowFirstCol;
    logic [1:0] countNext;
    logic [3:0] firstNext;
    frameRes_e  frameKind;

    assign rowLows     = countLow(colSync);
    assign rowFirstCol = lowestLow(colSync);

    // Rows are visited in ascending order, so the first row with a hit holds the lowest code.
    always_comb begin
        countNext = keyCount;
        firstNext = firstCode;
        if (({1'b0, keyCount} + rowLows) >= 3'd2) countNext = 2'd2;
        else                                       countNext = keyCount + rowLows[1:0];
        if (keyCount == 2'd0 && rowLows != 3'd0) firstNext = {rowIdx, rowFirstCol};
    end

    always_comb begin
        frameKind = MULTI;
        if (countNext == 2'd0)      frameKind = NONE;
        else if (countNext == 2'd1) frameKind = KEY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keyCount  <= '0;
            firstCode <= '0;
        end else if (frameDone) begin
            keyCount  <= '0;
            firstCode <= '0;
        end else if (sampleNow) begin
            keyCount  <= countNext;
            firstCode <= firstNext;
        end
    end

    kbdState_e        state, stateNext;
    logic [3:0]       cand, candNext;
    logic [CNT_W-1:0] stableCnt, stableNext;
    logic [CNT_W-1:0] relCnt, relNext;
    logic             acceptNow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= '0;
            stableCnt <= '0;
            relCnt    <= '0;
            keyCode   <= '0;
            keyValid  <= 1'b0;
        end else begin
            state     <= stateNext;
            cand      <= candNext;
            stableCnt <= stableNext;
            relCnt    <= relNext;
            keyValid  <= acceptNow;
            if (acceptNow) keyCode <= candNext;
        end
    end

    always_comb begin
        stateNext  = state;
        candNext   = cand;
        stableNext = stableCnt;
        relNext    = relCnt;
        acceptNow  = 1'b0;
        if (frameDone) begin
            case (state)
                IDLE, DEBOUNCE: begin
                    if (frameKind == KEY) begin
                        candNext   = firstNext;
                        stableNext = (state == DEBOUNCE && firstNext == cand)
                                     ? stableCnt + CNT_W'(1) : CNT_W'(1);
                        if (stableNext == CNT_TARGET) begin
                            acceptNow = 1'b1;
                            stateNext = HELD;
                            relNext   = '0;
                        end else begin
                            stateNext = DEBOUNCE;
                        end
                    end else begin
                        stateNext  = IDLE;
                        stableNext = '0;
                    end
                end
                HELD: begin
                    if (frameKind == NONE) begin
                        relNext = relCnt + CNT_W'(1);
                        if (relNext == CNT_TARGET) begin
                            stateNext  = IDLE;
                            relNext    = '0;
                            stableNext = '0;
                        end
                    end else begin
                        relNext = '0;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_comb begin
        keyHeld = (state == HELD);
    end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb/tb_key_matrix_scanner.sv - frame-level reference model bench for key_matrix_scanner
module tb_key_matrix_scanner;

    localparam int DF    = 2;
    localparam int FRAME = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] colIn;
    logic [3:0] rowOut;
    logic [3:0] keyCode;
    logic       keyValid;
    logic       keyHeld;
    logic [15:0] pressed = '0;

    int checks = 0;
    int passed = 0;

    int hist[$];
    bit mHeld = 1'b0;
    int mCode = 0;

    key_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(DF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .colIn    (colIn),
        .rowOut   (rowOut),
        .keyCode  (keyCode),
        .keyValid (keyValid),
        .keyHeld  (keyHeld)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] matrixCols(input logic [15:0] keys, input logic [3:0] rows);
        logic [3:0] c;
        c = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                if (rows[r] === 1'b0 && keys[r*4+k]) c[k] = 1'b0;
        return c;
    endfunction

    // Physical matrix: a pressed key shorts its row to its column.
    initial forever begin
        colIn = matrixCols(pressed, rowOut);
        @(pressed or rowOut);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // -1 = no key, -2 = several keys, otherwise the single key's code.
    function automatic int frameResult(input logic [15:0] mask);
        int n = 0;
        int idx = 0;
        for (int k = 15; k >= 0; k--) if (mask[k]) begin n++; idx = k; end
        if (n == 0) return -1;
        if (n == 1) return idx;
        return -2;
    endfunction

    function automatic int trailing(input int v);
        int n = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == v; i--) n++;
        return n;
    endfunction

    task automatic modelReset();
        hist.delete();
        mHeld = 1'b0;
        mCode = 0;
    endtask

    task automatic modelFrame(input logic [15:0] mask, output logic expValid);
        int res;
        res = frameResult(mask);
        hist.push_back(res);
        expValid = 1'b0;
        if (!mHeld) begin
            if (res >= 0 && trailing(res) == DF) begin
                expValid = 1'b1;
                mHeld    = 1'b1;
                mCode    = res;
            end
        end else if (trailing(-1) == DF) begin
            mHeld = 1'b0;
        end
    endtask

    task automatic runFrame(input logic [15:0] mask, input string tag);
        logic       expValid;
        logic       prevHeld;
        logic [3:0] expRow;
        prevHeld = mHeld;
        pressed  = mask;
        modelFrame(mask, expValid);
        for (int m = 1; m <= FRAME; m++) begin
            @(negedge clk);
            expRow = ~(4'b0001 << ((m / 4) % 4));
            chk({tag, "/rowOut"}, 16'(rowOut), 16'(expRow));
            if (m < FRAME) begin
                chk({tag, "/keyValidMid"}, 16'(keyValid), 16'd0);
                chk({tag, "/keyHeldMid"}, 16'(keyHeld), 16'(prevHeld));
            end else begin
                chk({tag, "/keyValid"}, 16'(keyValid), 16'(expValid));
                chk({tag, "/keyHeld"}, 16'(keyHeld), 16'(mHeld));
                chk({tag, "/keyCode"}, 16'(keyCode), 16'(mCode));
            end
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        logic [3:0] rowRst;
        rowRst = 4'b1110;
        chk({tag, "/rowOut"}, 16'(rowOut), 16'(rowRst));
        chk({tag, "/keyCode"}, 16'(keyCode), 16'd0);
        chk({tag, "/keyValid"}, 16'(keyValid), 16'd0);
        chk({tag, "/keyHeld"}, 16'(keyHeld), 16'd0);
    endtask

    initial begin
        logic [15:0] mask;
        int kind, len, a, b;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        modelReset();

        repeat (2) runFrame(16'h0000, "idle");

        repeat (6) runFrame(16'h0001 << 6, "key6");
        repeat (3) runFrame(16'h0000, "rel6");

        runFrame(16'h0001 << 15, "bounce15");
        runFrame(16'h0000, "bounce15");
        runFrame(16'h0001 << 15, "bounce15");
        runFrame(16'h0000, "bounce15");
        repeat (4) runFrame(16'h0001 << 15, "key15");
        repeat (2) runFrame(16'h0000, "rel15");

        repeat (3) runFrame(16'h0001 << 3, "key3");
        repeat (2) runFrame((16'h0001 << 3) | (16'h0001 << 12), "key3plus12");
        repeat (2) runFrame(16'h0000, "relBoth");
        repeat (3) runFrame(16'h0001 << 12, "key12");
        repeat (2) runFrame(16'h0000, "rel12");

        repeat (5) runFrame(16'h0001 | (16'h0001 << 5), "ghost0and5");
        repeat (2) runFrame(16'h0000, "relGhost");

        for (int s = 0; s < 20; s++) begin
            kind = $urandom_range(0, 3);
            len  = $urandom_range(1, 4);
            a    = $urandom_range(0, 15);
            b    = (a + $urandom_range(1, 15)) % 16;
            mask = '0;
            if (kind == 1 || kind == 2) mask[a] = 1'b1;
            if (kind == 3) begin mask[a] = 1'b1; mask[b] = 1'b1; end
            repeat (len) runFrame(mask, "random");
        end
        repeat (2) runFrame(16'h0000, "relRandom");

        repeat (3) runFrame(16'h0001 << 9, "key9");
        pressed = 16'h0001 << 9;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midReset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        repeat (3) runFrame(16'h0001 << 9, "key9AfterReset");
        repeat (2) runFrame(16'h0000, "rel9");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
